// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART host register bank.
// Register map, IIR codes and bit positions of LCR/LSR/IER.
package uart_pkg;

    localparam logic [2:0] A_RBR = 3'd0;
    localparam logic [2:0] A_IER = 3'd1;
    localparam logic [2:0] A_IIR = 3'd2;
    localparam logic [2:0] A_LCR = 3'd3;
    localparam logic [2:0] A_MCR = 3'd4;
    localparam logic [2:0] A_LSR = 3'd5;
    localparam logic [2:0] A_MSR = 3'd6;
    localparam logic [2:0] A_SCR = 3'd7;

    localparam logic [7:0] IIR_RLS  = 8'hC6;
    localparam logic [7:0] IIR_RDA  = 8'hC4;
    localparam logic [7:0] IIR_THRE = 8'hC2;
    localparam logic [7:0] IIR_NONE = 8'hC1;

    localparam int LCR_STB  = 2;
    localparam int LCR_PEN  = 3;
    localparam int LCR_EPS  = 4;
    localparam int LCR_DLAB = 7;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;
    localparam int LSR_ERR  = 7;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;
    localparam int IER_RLS  = 2;

    localparam logic [7:0] LCR_RESET = 8'h03;

endpackage

// File: rtl/uart_irq_prio.sv
// uart_irq_prio: 16550 interrupt identification priority encoder.
// Line status beats receive data, which beats transmitter empty.
module uart_irq_prio
    import uart_pkg::*;
(
    input  logic [2:0] i_ier,
    input  logic       i_ls_err,
    input  logic       i_rx_ready,
    input  logic       i_thre,
    output logic [7:0] o_iir
);

    always_comb begin
        o_iir = IIR_NONE;
        if (i_ier[IER_RLS] && i_ls_err)
            o_iir = IIR_RLS;
        else if (i_ier[IER_RDA] && i_rx_ready)
            o_iir = IIR_RDA;
        else if (i_ier[IER_THRE] && i_thre)
            o_iir = IIR_THRE;
    end

endmodule

// File: rtl/uart_host_regs.sv
// uart_host_regs: 16550-style CPU register bank in front of the UART core.
// Bus decode, line/baud config, sticky line status and prioritised irq.
module uart_host_regs
    import uart_pkg::*;
#(
    parameter int          DL_WIDTH  = 16,
    parameter int          PSD_WIDTH = 4,
    parameter logic [15:0] DL_RESET  = 16'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 we,
    input  logic [2:0]           addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    output logic                 irq,
    output logic                 wr_en,
    output logic [7:0]           wr_data,
    input  logic                 tx_ready,
    output logic                 rd_en,
    input  logic [7:0]           rd_data,
    input  logic                 rx_ready,
    input  logic                 parity_err,
    input  logic                 framing_err,
    input  logic                 overrun_err,
    output logic [1:0]           stop_bits,
    output logic                 parity_en,
    output logic                 parity_even,
    output logic [3:0]           data_bits,
    output logic [DL_WIDTH-1:0]  divisor_latch,
    output logic [PSD_WIDTH-1:0] psd,
    output logic                 new_baud
);

    logic       w_wr, w_rd, w_dlab;
    logic       w_thr_wr, w_rbr_rd, w_ier_wr;
    logic       w_iir_rd, w_lsr_rd, w_baud_wr;
    logic       w_oe_nxt, w_pe_nxt, w_fe_nxt;
    logic       w_thre_set, w_thre_clr, w_thre_nxt;
    logic [2:0] w_ier_nxt;
    logic [7:0] w_lsr, w_iir, w_iir_nxt, w_rmux;

    logic [7:0]           r_rdata, r_lcr, r_scr, r_fcr_unused;
    logic [4:0]           r_mcr;
    logic [2:0]           r_ier;
    logic [15:0]          r_dl;
    logic [PSD_WIDTH-1:0] r_psd;
    logic                 r_oe, r_pe, r_fe;
    logic                 r_thre, r_tx_q, r_irq, r_new_baud;

    assign w_wr      = cs & we;
    assign w_rd      = cs & ~we;
    assign w_dlab    = r_lcr[LCR_DLAB];
    assign w_thr_wr  = w_wr & (addr == A_RBR) & ~w_dlab;
    assign w_rbr_rd  = w_rd & (addr == A_RBR) & ~w_dlab;
    assign w_ier_wr  = w_wr & (addr == A_IER) & ~w_dlab;
    assign w_iir_rd  = w_rd & (addr == A_IIR);
    assign w_lsr_rd  = w_rd & (addr == A_LSR);
    assign w_baud_wr = w_wr & w_dlab &
                       ((addr == A_RBR) | (addr == A_IER) | (addr == A_LSR));

    assign wr_en   = w_thr_wr & tx_ready;
    assign wr_data = wdata;
    assign rd_en   = w_rbr_rd & rx_ready;

    assign w_lsr = {r_pe | r_fe, tx_ready, tx_ready, 1'b0,
                    r_fe, r_pe, r_oe, rx_ready};

    // A pulse landing on the LSR read cycle must survive the clear.
    assign w_oe_nxt = overrun_err | (r_oe & ~w_lsr_rd);
    assign w_pe_nxt = parity_err  | (r_pe & ~w_lsr_rd);
    assign w_fe_nxt = framing_err | (r_fe & ~w_lsr_rd);

    assign w_ier_nxt  = w_ier_wr ? wdata[2:0] : r_ier;
    assign w_thre_set = (tx_ready & ~r_tx_q) |
                        (w_ier_wr & wdata[IER_THRE] & ~r_ier[IER_THRE] & tx_ready);
    assign w_thre_clr = w_thr_wr | (w_iir_rd & (w_iir == IIR_THRE));
    assign w_thre_nxt = w_thre_set | (r_thre & ~w_thre_clr);

    uart_irq_prio u_prio_cur (
        .i_ier      (r_ier),
        .i_ls_err   (r_oe | r_pe | r_fe),
        .i_rx_ready (rx_ready),
        .i_thre     (r_thre),
        .o_iir      (w_iir)
    );

    uart_irq_prio u_prio_nxt (
        .i_ier      (w_ier_nxt),
        .i_ls_err   (w_oe_nxt | w_pe_nxt | w_fe_nxt),
        .i_rx_ready (rx_ready),
        .i_thre     (w_thre_nxt),
        .o_iir      (w_iir_nxt)
    );

    always_comb begin
        w_rmux = 8'h00;
        case (addr)
            A_RBR:   w_rmux = w_dlab ? r_dl[7:0] : (rx_ready ? rd_data : 8'h00);
            A_IER:   w_rmux = w_dlab ? r_dl[15:8] : {5'b0, r_ier};
            A_IIR:   w_rmux = w_iir;
            A_LCR:   w_rmux = r_lcr;
            A_MCR:   w_rmux = {3'b0, r_mcr};
            A_LSR:   w_rmux = w_lsr;
            A_SCR:   w_rmux = r_scr;
            default: w_rmux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata      <= 8'h00;
            r_lcr        <= LCR_RESET;
            r_mcr        <= 5'd0;
            r_scr        <= 8'h00;
            r_fcr_unused <= 8'h00;
            r_ier        <= 3'd0;
            r_dl         <= DL_RESET;
            r_psd        <= '0;
            r_oe         <= 1'b0;
            r_pe         <= 1'b0;
            r_fe         <= 1'b0;
            r_thre       <= 1'b0;
            r_tx_q       <= 1'b1;
            r_irq        <= 1'b0;
            r_new_baud   <= 1'b0;
        end else begin
            r_oe       <= w_oe_nxt;
            r_pe       <= w_pe_nxt;
            r_fe       <= w_fe_nxt;
            r_thre     <= w_thre_nxt;
            r_tx_q     <= tx_ready;
            r_ier      <= w_ier_nxt;
            r_irq      <= ~w_iir_nxt[0];
            r_new_baud <= w_baud_wr;
            if (w_rd)
                r_rdata <= w_rmux;
            if (w_wr) begin
                case (addr)
                    A_RBR:   if (w_dlab) r_dl[7:0] <= wdata;
                    A_IER:   if (w_dlab) r_dl[15:8] <= wdata;
                    A_IIR:   r_fcr_unused <= wdata;
                    A_LCR:   r_lcr <= wdata;
                    A_MCR:   r_mcr <= wdata[4:0];
                    A_LSR:   if (w_dlab) r_psd <= PSD_WIDTH'(wdata);
                    A_SCR:   r_scr <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign rdata         = r_rdata;
    assign irq           = r_irq;
    assign new_baud      = r_new_baud;
    assign divisor_latch = DL_WIDTH'(r_dl);
    assign psd           = r_psd;
    assign data_bits     = 4'd5 + {2'b00, r_lcr[1:0]};
    assign stop_bits     = r_lcr[LCR_STB] ? 2'd2 : 2'd1;
    assign parity_en     = r_lcr[LCR_PEN];
    assign parity_even   = r_lcr[LCR_EPS];

endmodule

// File: tb/tb_uart_host_regs.sv
// tb_uart_host_regs: directed vector table plus randomized traffic
// checked against a register-level model of the 16550 host bank.
module tb_uart_host_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  wdata = 8'h00;
    logic        tx_ready = 1'b1, rx_ready = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        pe_i = 1'b0, fe_i = 1'b0, oe_i = 1'b0;
    logic [7:0]  rdata, wr_data;
    logic        irq, wr_en, rd_en, parity_en, parity_even, new_baud;
    logic [1:0]  stop_bits;
    logic [3:0]  data_bits;
    logic [15:0] divisor_latch;
    logic [3:0]  psd;

    uart_host_regs dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq),
        .wr_en(wr_en), .wr_data(wr_data), .tx_ready(tx_ready),
        .rd_en(rd_en), .rd_data(rd_data), .rx_ready(rx_ready),
        .parity_err(pe_i), .framing_err(fe_i), .overrun_err(oe_i),
        .stop_bits(stop_bits), .parity_en(parity_en),
        .parity_even(parity_even), .data_bits(data_bits),
        .divisor_latch(divisor_latch), .psd(psd), .new_baud(new_baud)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int nb_count = 0;
    logic last_wr_en;

    // reference model state, register-level view
    logic [2:0]  m_ier;
    logic [7:0]  m_lcr, m_mcr, m_scr, m_rdata;
    logic [15:0] m_dl;
    logic [3:0]  m_psd;
    logic        m_oe, m_pe, m_fe, m_thre, m_prev_tx, m_irq, m_nb;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wd;
        logic       tx;
        logic       rx;
        logic [7:0] rdd;
        logic [2:0] err;
        logic       chk;
        logic [7:0] exp;
        logic [1:0] irqe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic [2:0] a,
                                input logic [7:0] d, input logic t, r,
                                input logic [7:0] rd, input logic [2:0] e,
                                input logic c, input logic [7:0] x,
                                input logic [1:0] q);
        vec_t v;
        v.we = w; v.addr = a; v.wd = d; v.tx = t; v.rx = r;
        v.rdd = rd; v.err = e; v.chk = c; v.exp = x; v.irqe = q;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_iir_of(input logic [2:0] ier,
                                            input logic err, rx, thre);
        if (ier[2] && err) return 8'hC6;
        if (ier[0] && rx) return 8'hC4;
        if (ier[1] && thre) return 8'hC2;
        return 8'hC1;
    endfunction

    task automatic m_reset();
        m_ier = 0; m_lcr = 8'h03; m_mcr = 0; m_scr = 0; m_rdata = 0;
        m_dl = 16'd1; m_psd = 0; m_oe = 0; m_pe = 0; m_fe = 0;
        m_thre = 0; m_prev_tx = 1; m_irq = 0; m_nb = 0;
    endtask

    task automatic m_step();
        logic dlab, rd, wr, set, clr;
        logic [7:0] iir, lsr;
        dlab = m_lcr[7];
        rd = cs && !we;
        wr = cs && we;
        iir = m_iir_of(m_ier, m_oe | m_pe | m_fe, rx_ready, m_thre);
        lsr = {m_pe | m_fe, tx_ready, tx_ready, 1'b0, m_fe, m_pe, m_oe, rx_ready};
        if (rd) begin
            case (addr)
                3'd0: m_rdata = dlab ? m_dl[7:0] : (rx_ready ? rd_data : 8'h00);
                3'd1: m_rdata = dlab ? m_dl[15:8] : {5'b0, m_ier};
                3'd2: m_rdata = iir;
                3'd3: m_rdata = m_lcr;
                3'd4: m_rdata = m_mcr;
                3'd5: m_rdata = lsr;
                3'd6: m_rdata = 8'h00;
                default: m_rdata = m_scr;
            endcase
        end
        set = (tx_ready && !m_prev_tx) ||
              (wr && addr == 1 && !dlab && wdata[1] && !m_ier[1] && tx_ready);
        clr = (wr && addr == 0 && !dlab) || (rd && addr == 2 && iir == 8'hC2);
        m_thre = set || (m_thre && !clr);
        if (rd && addr == 5) begin
            m_oe = 0; m_pe = 0; m_fe = 0;
        end
        m_oe = m_oe | oe_i;
        m_pe = m_pe | pe_i;
        m_fe = m_fe | fe_i;
        m_nb = wr && dlab && (addr == 0 || addr == 1 || addr == 5);
        if (wr) begin
            case (addr)
                3'd0: if (dlab) m_dl[7:0] = wdata;
                3'd1: if (dlab) m_dl[15:8] = wdata; else m_ier = wdata[2:0];
                3'd3: m_lcr = wdata;
                3'd4: m_mcr = {3'b0, wdata[4:0]};
                3'd5: if (dlab) m_psd = wdata[3:0];
                3'd7: m_scr = wdata;
                default: ;
            endcase
        end
        m_prev_tx = tx_ready;
        m_irq = m_iir_of(m_ier, m_oe | m_pe | m_fe, rx_ready, m_thre) != 8'hC1;
    endtask

    task automatic drive(input logic c, w, input logic [2:0] a,
                         input logic [7:0] d);
        logic exp_wr, exp_rd;
        logic [7:0] exp_line;
        cs = c; we = w; addr = a; wdata = d;
        #1;
        exp_wr = c && w && a == 0 && !m_lcr[7] && tx_ready;
        exp_rd = c && !w && a == 0 && !m_lcr[7] && rx_ready;
        check("wr_en", wr_en, exp_wr);
        check("rd_en", rd_en, exp_rd);
        if (exp_wr) check("wr_data", wr_data, d);
        last_wr_en = wr_en;
        @(posedge clk);
        m_step();
        #1;
        exp_line = {(m_lcr[2] ? 2'd2 : 2'd1), m_lcr[3], m_lcr[4],
                    4'(5 + m_lcr[1:0])};
        check("rdata", rdata, m_rdata);
        check("irq", irq, m_irq);
        check("new_baud", new_baud, m_nb);
        check("divisor", divisor_latch, m_dl);
        check("psd", psd, m_psd);
        check("line_ctrl", {stop_bits, parity_en, parity_even, data_bits}, exp_line);
        if (new_baud) nb_count++;
        cs = 0; we = 0; pe_i = 0; fe_i = 0; oe_i = 0;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            tx_ready = tbl[i].tx;
            rx_ready = tbl[i].rx;
            rd_data = tbl[i].rdd;
            {oe_i, pe_i, fe_i} = tbl[i].err;
            drive(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd);
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp);
            if (tbl[i].irqe != 2) check($sformatf("vec%0d_irq", i), irq, tbl[i].irqe[0]);
        end
        tbl.delete();
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_new_baud", new_baud, 1'b0);
        check("rst_divisor", divisor_latch, 16'd1);
        check("rst_psd", psd, 4'd0);
        check("rst_data_bits", data_bits, 4'd8);
        check("rst_stop_bits", stop_bits, 2'd1);
        check("rst_parity_en", parity_en, 1'b0);

        tbl.push_back(mk(0, 3, 8'h00, 1, 0, 0, 0, 1, 8'h03, 0));
        tbl.push_back(mk(0, 2, 8'h00, 1, 0, 0, 0, 1, 8'hC1, 0));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 0, 1, 8'h60, 0));
        tbl.push_back(mk(1, 3, 8'h80, 1, 0, 0, 0, 0, 8'h00, 2));
        tbl.push_back(mk(1, 0, 8'h34, 1, 0, 0, 0, 0, 8'h00, 2));
        tbl.push_back(mk(1, 1, 8'h12, 1, 0, 0, 0, 0, 8'h00, 2));
        tbl.push_back(mk(1, 5, 8'h03, 1, 0, 0, 0, 0, 8'h00, 2));
        tbl.push_back(mk(1, 3, 8'h1B, 1, 0, 0, 0, 0, 8'h00, 2));
        nb_count = 0;
        run_tbl();
        check("cfg_divisor", divisor_latch, 16'h1234);
        check("cfg_psd", psd, 4'd3);
        check("cfg_new_baud_pulses", nb_count, 3);
        check("cfg_data_bits", data_bits, 4'd8);
        check("cfg_parity", {parity_en, parity_even}, 2'b11);

        tx_ready = 1;
        drive(1, 1, 0, 8'hA5);
        check("thr_push", last_wr_en, 1'b1);
        tx_ready = 0;
        drive(1, 1, 0, 8'hA5);
        check("thr_full_drop", last_wr_en, 1'b0);

        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h5A, 0, 1, 8'h5A, 2));
        tbl.push_back(mk(1, 1, 8'h01, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 2, 8'h00, 1, 1, 0, 0, 1, 8'hC4, 1));
        tbl.push_back(mk(1, 1, 8'h05, 1, 0, 0, 3'b001, 0, 8'h00, 1));
        tbl.push_back(mk(0, 2, 8'h00, 1, 0, 0, 0, 1, 8'hC6, 1));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 0, 1, 8'hE8, 0));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 0, 1, 8'h60, 0));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 3'b001, 1, 8'h60, 1));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 0, 1, 8'hE8, 0));
        tbl.push_back(mk(0, 5, 8'h00, 1, 0, 0, 0, 1, 8'h60, 0));
        tbl.push_back(mk(1, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'h02, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 2, 8'h00, 1, 0, 0, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(0, 2, 8'h00, 1, 0, 0, 0, 1, 8'hC1, 0));
        tbl.push_back(mk(1, 7, 8'h5C, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 7, 8'h00, 1, 0, 0, 0, 1, 8'h5C, 1));
        tbl.push_back(mk(0, 2, 8'h00, 1, 0, 0, 0, 1, 8'hC2, 0));
        run_tbl();

        for (int i = 0; i < 1500; i++) begin
            tx_ready = $urandom_range(0, 3) != 0;
            rx_ready = $urandom_range(0, 1) != 0;
            rd_data = 8'($urandom);
            oe_i = $urandom_range(0, 7) == 0;
            pe_i = $urandom_range(0, 7) == 0;
            fe_i = $urandom_range(0, 7) == 0;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  3'($urandom), 8'($urandom));
        end

        tx_ready = 1;
        drive(1, 1, 3, 8'h80);
        cs = 1; we = 1; addr = 0; wdata = 8'h77;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_new_baud", new_baud, 1'b0);
        check("midrst_divisor", divisor_latch, 16'd1);
        check("midrst_data_bits", data_bits, 4'd8);
        check("midrst_rdata", rdata, 8'h00);
        check("midrst_irq", irq, 1'b0);
        cs = 0; we = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
